tx_ingress_queue: RTL and testbench

//  Ingress stage directly upstream of the ledger settlement core: accepts transactions from the host over valid/ready,

---
 rtl/tx_ingress_queue.sv | 166 ++++++++++++++++
 tb/tb_tx_ingress_queue.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_ingress_queue.sv
// Ingress queue feeding the ledger settlement core: screens host transactions,
// buffers accepted ones in a FIFO and issues at most one per cycle on s_*.
module tx_ingress_queue #(
    parameter int unsigned USER_WIDTH    = 10,
    parameter int unsigned BALANCE_WIDTH = 64,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned CNT_WIDTH     = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_opcode,
    input  logic [USER_WIDTH-1:0]        in_user_a,
    input  logic [USER_WIDTH-1:0]        in_user_b,
    input  logic [BALANCE_WIDTH-1:0]     in_amount_0,
    input  logic [BALANCE_WIDTH-1:0]     in_amount_1,
    input  logic                         issue_en,
    output logic                         s_valid,
    output logic                         s_opcode,
    output logic [USER_WIDTH-1:0]        s_user_a,
    output logic [USER_WIDTH-1:0]        s_user_b,
    output logic [BALANCE_WIDTH-1:0]     s_amount_0,
    output logic [BALANCE_WIDTH-1:0]     s_amount_1,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic [CNT_WIDTH-1:0]         cnt_accepted,
    output logic [CNT_WIDTH-1:0]         cnt_rejected,
    output logic [CNT_WIDTH-1:0]         cnt_issued
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic                     opcode;
        logic [USER_WIDTH-1:0]    user_a;
        logic [USER_WIDTH-1:0]    user_b;
        logic [BALANCE_WIDTH-1:0] amount_0;
        logic [BALANCE_WIDTH-1:0] amount_1;
    } txn_t;

    txn_t                 r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [LVL_W-1:0]     r_level;
    logic                 r_push_d;
    logic                 r_s_valid;
    txn_t                 r_s_txn;
    logic [CNT_WIDTH-1:0] r_cnt_acc;
    logic [CNT_WIDTH-1:0] r_cnt_rej;
    logic [CNT_WIDTH-1:0] r_cnt_iss;

    txn_t                 w_in_txn;
    txn_t                 w_head;
    logic                 w_ready;
    logic                 w_fire;
    logic                 w_amt_bad;
    logic                 w_zero_bad;
    logic                 w_reject;
    logic                 w_push;
    logic                 w_avail;
    logic                 w_pop;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign w_in_txn = '{opcode:   in_opcode,
                        user_a:   in_user_a,
                        user_b:   in_user_b,
                        amount_0: in_amount_0,
                        amount_1: in_amount_1};

    // Ready depends only on registered level and flush, never on in_valid.
    assign w_ready = !flush && (r_level < LVL_W'(DEPTH));
    assign w_fire  = in_valid && w_ready;

    // MSB guard keeps amount+fee arithmetic in the core from overflowing.
    assign w_amt_bad  = in_amount_0[BALANCE_WIDTH-1] | in_amount_1[BALANCE_WIDTH-1];
    assign w_zero_bad = in_opcode ? ((in_amount_0 == '0) || (in_amount_1 == '0))
                                  : (in_amount_0 == '0);
    assign w_reject   = w_fire && (w_amt_bad || w_zero_bad);
    assign w_push     = w_fire && !w_reject;

    // An entry written on the previous edge is not yet eligible: no bypass path.
    assign w_avail = r_level > LVL_W'(r_push_d);
    assign w_pop   = issue_en && w_avail && !flush;
    assign w_head  = r_mem[r_rd_ptr];

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_push_d <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_push_d <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_level  <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
            r_push_d <= w_push;
        end
    end

    // Storage array; contents are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_txn;
        end
    end

    // Issue register toward the core; payload holds when nothing is popped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_valid <= 1'b0;
            r_s_txn   <= '0;
        end else begin
            r_s_valid <= w_pop;
            if (w_pop) begin
                r_s_txn <= w_head;
            end
        end
    end

    // Saturating statistics; flush leaves them untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_acc <= '0;
            r_cnt_rej <= '0;
            r_cnt_iss <= '0;
        end else begin
            if (w_push) begin
                r_cnt_acc <= sat_inc(r_cnt_acc);
            end
            if (w_reject) begin
                r_cnt_rej <= sat_inc(r_cnt_rej);
            end
            if (w_pop) begin
                r_cnt_iss <= sat_inc(r_cnt_iss);
            end
        end
    end

    assign in_ready     = w_ready;
    assign s_valid      = r_s_valid;
    assign s_opcode     = r_s_txn.opcode;
    assign s_user_a     = r_s_txn.user_a;
    assign s_user_b     = r_s_txn.user_b;
    assign s_amount_0   = r_s_txn.amount_0;
    assign s_amount_1   = r_s_txn.amount_1;
    assign fifo_level   = r_level;
    assign cnt_accepted = r_cnt_acc;
    assign cnt_rejected = r_cnt_rej;
    assign cnt_issued   = r_cnt_iss;

endmodule

// File: tb/tb_tx_ingress_queue.sv
// Directed self-checking bench for tx_ingress_queue.
module tb_tx_ingress_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_opcode = 1'b0;
    logic [9:0]  in_user_a = '0;
    logic [9:0]  in_user_b = '0;
    logic [63:0] in_amount_0 = '0;
    logic [63:0] in_amount_1 = '0;
    logic        issue_en = 1'b0;
    logic        s_valid;
    logic        s_opcode;
    logic [9:0]  s_user_a;
    logic [9:0]  s_user_b;
    logic [63:0] s_amount_0;
    logic [63:0] s_amount_1;
    logic [4:0]  fifo_level;
    logic [31:0] cnt_accepted;
    logic [31:0] cnt_rejected;
    logic [31:0] cnt_issued;

    tx_ingress_queue #(
        .USER_WIDTH(10), .BALANCE_WIDTH(64), .DEPTH(16), .CNT_WIDTH(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_user_a(in_user_a), .in_user_b(in_user_b),
        .in_amount_0(in_amount_0), .in_amount_1(in_amount_1),
        .issue_en(issue_en), .s_valid(s_valid), .s_opcode(s_opcode),
        .s_user_a(s_user_a), .s_user_b(s_user_b),
        .s_amount_0(s_amount_0), .s_amount_1(s_amount_1),
        .fifo_level(fifo_level), .cnt_accepted(cnt_accepted),
        .cnt_rejected(cnt_rejected), .cnt_issued(cnt_issued)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [9:0]  a;
        logic [9:0]  b;
        logic [63:0] x0;
        logic [63:0] x1;
        int          cyc;
    } obs_t;

    obs_t obs_q[$];
    obs_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   exp_acc = 0;
    int   exp_rej = 0;
    int   exp_iss = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every issued transaction with the cycle it appeared in
    always @(negedge clk) begin
        if (s_valid === 1'b1) begin
            obs_q.push_back('{s_opcode, s_user_a, s_user_b, s_amount_0, s_amount_1, cyc});
        end
    end

    function automatic obs_t mk(input logic op, input logic [9:0] a, input logic [9:0] b,
                                input logic [63:0] x0, input logic [63:0] x1);
        obs_t o;
        o.op = op; o.a = a; o.b = b; o.x0 = x0; o.x1 = x1; o.cyc = 0;
        return o;
    endfunction

    function automatic bit same(input obs_t p, input obs_t q);
        return (p.op === q.op) && (p.a === q.a) && (p.b === q.b) &&
               (p.x0 === q.x0) && (p.x1 === q.x1);
    endfunction

    // Present one transaction from a negedge; returns at the negedge after it was taken
    task automatic push(input logic op, input logic [9:0] a, input logic [9:0] b,
                        input logic [63:0] x0, input logic [63:0] x1);
        bit ok;
        logic rdy;
        ok = 1'b0;
        in_opcode = op; in_user_a = a; in_user_b = b; in_amount_0 = x0; in_amount_1 = x1;
        in_valid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            rdy = in_ready;
            @(posedge clk);
            if (rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
            #1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (!ok) begin
            checks++; failures++;
            $display("FAIL push_timeout: in_ready never high for a=%0d", a);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({s_valid, fifo_level, cnt_accepted, cnt_rejected, cnt_issued, s_user_a, s_amount_0} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: s_valid=%0b level=%0d acc=%0d rej=%0d iss=%0d expected all 0",
                     s_valid, fifo_level, cnt_accepted, cnt_rejected, cnt_issued);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        int hs;
        issue_en = 1'b1;
        obs_q.delete();
        push(1'b0, 10'd3, 10'd7, 64'd1000, 64'd0);
        hs = cyc;
        exp_acc++; exp_iss++;
        repeat (5) @(negedge clk);
        checks++;
        if (obs_q.size() != 1) begin
            failures++; $display("FAIL single_count: got %0d issues expected 1", obs_q.size());
        end else begin
            checks++;
            if (!same(obs_q[0], mk(1'b0, 10'd3, 10'd7, 64'd1000, 64'd0))) begin
                failures++;
                $display("FAIL single_fields: op=%0b a=%0d b=%0d amt0=%0d expected 0/3/7/1000",
                         obs_q[0].op, obs_q[0].a, obs_q[0].b, obs_q[0].x0);
            end
            checks++;
            if (obs_q[0].cyc - hs != 2) begin
                failures++; $display("FAIL single_latency: got %0d cycles expected 2", obs_q[0].cyc - hs);
            end
        end
    endtask

    task automatic test_full();
        bit order_ok;
        issue_en = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            push(1'b0, 10'(i + 100), 10'(i + 200), 64'(5 + i), 64'd0);
            exp_q.push_back(mk(1'b0, 10'(i + 100), 10'(i + 200), 64'(5 + i), 64'd0));
        end
        exp_acc += 16;
        checks++;
        if (fifo_level !== 5'd16 || in_ready !== 1'b0) begin
            failures++; $display("FAIL full_level: level=%0d ready=%0b expected 16/0", fifo_level, in_ready);
        end
        in_opcode = 1'b0; in_user_a = 10'd999; in_amount_0 = 64'd1; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (fifo_level !== 5'd16 || cnt_accepted !== 32'(exp_acc)) begin
            failures++;
            $display("FAIL full_17th_taken: level=%0d acc=%0d expected 16/%0d", fifo_level, cnt_accepted, exp_acc);
        end
        in_valid = 1'b0;
        obs_q.delete();
        issue_en = 1'b1;
        repeat (20) @(negedge clk);
        exp_iss += 16;
        checks++;
        if (obs_q.size() != 16) begin
            failures++; $display("FAIL full_drain_count: got %0d expected 16", obs_q.size());
        end else begin
            order_ok = 1'b1;
            for (int i = 0; i < 16; i++) begin
                if (!same(obs_q[i], exp_q[i]) || obs_q[i].cyc != obs_q[0].cyc + i) order_ok = 1'b0;
            end
            checks++;
            if (!order_ok) begin
                failures++; $display("FAIL full_drain_order: got first a=%0d expected in-order back-to-back from a=100", obs_q[0].a);
            end
        end
        checks++;
        if (cnt_issued !== 32'(exp_iss) || fifo_level !== 5'd0) begin
            failures++; $display("FAIL full_counters: iss=%0d level=%0d expected %0d/0", cnt_issued, fifo_level, exp_iss);
        end
    endtask

    task automatic test_screen();
        issue_en = 1'b1;
        obs_q.delete();
        push(1'b0, 10'd1, 10'd2, 64'd0, 64'd0);
        push(1'b1, 10'd1, 10'd2, 64'd50, 64'd0);
        push(1'b0, 10'd1, 10'd2, 64'h8000_0000_0000_0000, 64'd0);
        exp_rej += 3;
        repeat (4) @(negedge clk);
        checks++;
        if (cnt_rejected !== 32'(exp_rej) || cnt_accepted !== 32'(exp_acc)) begin
            failures++;
            $display("FAIL screen_counts: rej=%0d acc=%0d expected %0d/%0d", cnt_rejected, cnt_accepted, exp_rej, exp_acc);
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++; $display("FAIL screen_issue: got %0d issues expected 0", obs_q.size());
        end
        push(1'b1, 10'd4, 10'd4, 64'd9, 64'd11);
        exp_acc++; exp_iss++;
        repeat (4) @(negedge clk);
        checks++;
        if (obs_q.size() != 1 || cnt_accepted !== 32'(exp_acc)) begin
            failures++; $display("FAIL screen_self_swap: issues=%0d acc=%0d expected 1/%0d", obs_q.size(), cnt_accepted, exp_acc);
        end
    endtask

    task automatic test_wrap();
        bit lvl_ok;
        bit order_ok;
        issue_en = 1'b0;
        exp_q.delete();
        obs_q.delete();
        lvl_ok = 1'b1;
        for (int i = 0; i < 25; i++) begin
            if (i == 5) issue_en = 1'b1;
            push(1'b1, 10'(300 + i), 10'(i), 64'(7000 + i), 64'(40 + i));
            exp_q.push_back(mk(1'b1, 10'(300 + i), 10'(i), 64'(7000 + i), 64'(40 + i)));
            if (i >= 5 && fifo_level !== 5'd5) lvl_ok = 1'b0;
        end
        exp_acc += 25; exp_iss += 25;
        checks++;
        if (!lvl_ok) begin
            failures++; $display("FAIL wrap_level: level=%0d expected steady 5", fifo_level);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (obs_q.size() != 25) begin
            failures++; $display("FAIL wrap_count: got %0d expected 25", obs_q.size());
        end else begin
            order_ok = 1'b1;
            for (int i = 0; i < 25; i++) if (!same(obs_q[i], exp_q[i])) order_ok = 1'b0;
            checks++;
            if (!order_ok) begin
                failures++; $display("FAIL wrap_order: got first a=%0d expected order a=300..324", obs_q[0].a);
            end
        end
    endtask

    task automatic test_flush();
        issue_en = 1'b0;
        for (int i = 0; i < 8; i++) push(1'b0, 10'(i), 10'(i + 1), 64'(20 + i), 64'd0);
        exp_acc += 8;
        checks++;
        if (fifo_level !== 5'd8) begin
            failures++; $display("FAIL flush_pre_level: got %0d expected 8", fifo_level);
        end
        obs_q.delete();
        flush = 1'b1; issue_en = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL flush_in_ready: got %0b expected 0", in_ready);
        end
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (fifo_level !== 5'd0 || s_valid !== 1'b0) begin
            failures++; $display("FAIL flush_level: level=%0d s_valid=%0b expected 0/0", fifo_level, s_valid);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (obs_q.size() != 0 || cnt_accepted !== 32'(exp_acc) || cnt_issued !== 32'(exp_iss) ||
            cnt_rejected !== 32'(exp_rej)) begin
            failures++;
            $display("FAIL flush_post: issues=%0d acc=%0d iss=%0d expected 0/%0d/%0d",
                     obs_q.size(), cnt_accepted, cnt_issued, exp_acc, exp_iss);
        end
    endtask

    task automatic test_async_reset();
        int hs;
        issue_en = 1'b0;
        for (int i = 0; i < 4; i++) push(1'b0, 10'(50 + i), 10'd1, 64'(90 + i), 64'd0);
        issue_en = 1'b1;
        @(negedge clk);
        checks++;
        if (s_valid !== 1'b1) begin
            failures++; $display("FAIL areset_pre: s_valid=%0b expected 1", s_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (s_valid !== 1'b0 || fifo_level !== 5'd0 || cnt_issued !== 32'd0) begin
            failures++; $display("FAIL areset_async: s_valid=%0b level=%0d iss=%0d expected 0/0/0", s_valid, fifo_level, cnt_issued);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        obs_q.delete();
        push(1'b1, 10'd12, 10'd13, 64'd777, 64'd888);
        hs = cyc;
        repeat (4) @(negedge clk);
        checks++;
        if (obs_q.size() != 1) begin
            failures++; $display("FAIL areset_after_count: got %0d expected 1", obs_q.size());
        end else begin
            checks++;
            if (!same(obs_q[0], mk(1'b1, 10'd12, 10'd13, 64'd777, 64'd888)) || obs_q[0].cyc - hs != 2) begin
                failures++;
                $display("FAIL areset_after_txn: a=%0d amt1=%0d lat=%0d expected 12/888/2",
                         obs_q[0].a, obs_q[0].x1, obs_q[0].cyc - hs);
            end
        end
        checks++;
        if (cnt_accepted !== 32'd1 || cnt_issued !== 32'd1 || cnt_rejected !== 32'd0) begin
            failures++; $display("FAIL areset_counters: acc=%0d iss=%0d rej=%0d expected 1/1/0", cnt_accepted, cnt_issued, cnt_rejected);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_screen();
        test_wrap();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
